regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of writeback requesters (0=ALU, 1=LOAD, 2=MULDIV).
REQ-002 Parameter XLEN, default 32: register data width.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester writeback request.
REQ-006 req_ready  out  NREQ  per-requester grant; a transfer occurs when valid and ready are both 1 at a posedge.
REQ-007 req_rd  in  NREQ*5  destination register index, requester i in bits [5i+4:5i].
REQ-008 req_data  in  NREQ*XLEN  writeback data, requester i in bits [XLEN*i+XLEN-1:XLEN*i].
REQ-009 issue_valid  in  1  an instruction with a destination register issues this cycle.
REQ-010 issue_rd  in  5  destination of the issuing instruction.
REQ-011 chk_rs1, chk_rs2  in  5 each  source indices to hazard-check.
REQ-012 rs1_busy, rs2_busy  out  1 each  source has a pending write.
REQ-013 flush  in  1  synchronous pipeline flush.
REQ-014 wb_we, wb_rd, wb_data  out  1/5/XLEN  register-file write port (drives writeEnable/rd/data).

Function
REQ-015 The block SHALL grant at most one requester per cycle, with req_ready combinational from req_valid and the pointer.
REQ-016 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NREQ; last_grant updates only on a transfer.
REQ-017 An idle requester SHALL never block others; with a single valid requester it SHALL be granted that cycle.
REQ-018 On a transfer from requester i with rd!=0, the next cycle SHALL show wb_we=1, wb_rd=req_rd[i], wb_data=req_data[i] (latency 1, registered).
REQ-019 A transfer with rd=0 SHALL be accepted (ready=1) but SHALL produce wb_we=0.
REQ-020 With no transfer, wb_we SHALL be 0 next cycle; wb_rd/wb_data SHALL hold their last values.
REQ-021 A 32-bit busy vector SHALL be maintained; busy[0] SHALL always read 0.
REQ-022 issue_valid with issue_rd!=0 SHALL set busy[issue_rd] at the posedge.
REQ-023 A transfer with rd!=0 SHALL clear busy[rd] at the same posedge that registers wb_*.
REQ-024 Simultaneous set and clear of the same index SHALL leave it set (set wins).
REQ-025 rsN_busy SHALL equal busy[chk_rsN] OR (wb_we AND wb_rd==chk_rsN AND chk_rsN!=0), combinationally.
REQ-026 flush SHALL clear the whole busy vector at the posedge, overriding a same-cycle issue set; arbitration and wb_* are unaffected by flush.

Reset
REQ-027 While rst_n=0: wb_we=0, wb_rd=0, wb_data=0, busy=0, last_grant=NREQ-1 (requester 0 first priority after reset).
REQ-028 Reset assertion mid-transfer SHALL discard the pending write; no wb_we pulse after rst_n rises without a new transfer.
REQ-029 req_ready MAY be asserted during reset but no transfer SHALL be recorded.

Structure
REQ-030 Package regfile_ctrl_pkg SHALL hold XLEN, REG_ADDR_W=5, NREQ, and enum wb_src_e {WB_ALU, WB_LOAD, WB_MULDIV}.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs valid vector, pointer; output one-hot grant).

Verification
REQ-032 Reset: rst_n=0 with all valids 1 -> wb_we=0, busy all 0; after release, first grant is requester 0.
REQ-033 Fairness: all three valid for 6 cycles -> grant order 0,1,2,0,1,2; each wb_we cycle carries matching rd/data.
REQ-034 Single write: LOAD valid, rd=5, data=0xDEADBEEF -> next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF.
REQ-035 x0: ALU valid, rd=0, data=0x1234 -> ready=1, following cycle wb_we=0; chk_rs1=0 -> rs1_busy=0.
REQ-036 Scoreboard: issue rd=7; chk_rs2=7 -> rs2_busy=1 until ALU writes rd=7; same-cycle issue rd=7 and write rd=7 -> remains busy.
REQ-037 Flush/reset mid-op: busy{3,9} set, flush=1 -> both clear next cycle; rst_n pulse during transfer -> no wb_we afterwards.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctrl_pkg
// Description : Shared widths and writeback-source encoding for the
//               register-file control slice.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREQ       = 3;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LOAD   = 2'd1,
        WB_MULDIV = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant; the search starts one past
//               the last granted index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int               w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && valid[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin writeback arbiter with registered register-file
//               write port and a destination-busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREQ = regfile_ctrl_pkg::NREQ,
    parameter int XLEN = regfile_ctrl_pkg::XLEN
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NREQ-1:0]                          req_valid,
    output logic [NREQ-1:0]                          req_ready,
    input  logic [NREQ*regfile_ctrl_pkg::REG_ADDR_W-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]                     req_data,
    input  logic                                     issue_valid,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0]  issue_rd,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0]  chk_rs1,
    input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0]  chk_rs2,
    output logic                                     rs1_busy,
    output logic                                     rs2_busy,
    input  logic                                     flush,
    output logic                                     wb_we,
    output logic [regfile_ctrl_pkg::REG_ADDR_W-1:0]  wb_rd,
    output logic [XLEN-1:0]                          wb_data
);

    import regfile_ctrl_pkg::*;

    localparam int         PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         NREGS    = 1 << REG_ADDR_W;
    localparam logic [PTR_W-1:0] c_PTR_RST = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]       r_last_grant;
    logic [NREQ-1:0]        w_grant;
    logic                   w_xfer;
    logic [PTR_W-1:0]       w_gidx;
    logic [REG_ADDR_W-1:0]  w_sel_rd;
    logic [XLEN-1:0]        w_sel_data;
    logic                   w_sel_nz;

    logic                   r_wb_we;
    logic [REG_ADDR_W-1:0]  r_wb_rd;
    logic [XLEN-1:0]        r_wb_data;

    logic [NREGS-1:0]       r_busy;
    logic [NREGS-1:0]       w_busy_set;
    logic [NREGS-1:0]       w_busy_clr;
    logic [NREGS-1:0]       w_busy_nxt;

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (r_last_grant),
        .grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);

    always_comb begin
        w_gidx     = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx     = PTR_W'(i);
                w_sel_rd   = req_rd[REG_ADDR_W*i +: REG_ADDR_W];
                w_sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    assign w_sel_nz = (w_sel_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_PTR_RST;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            r_wb_we <= w_xfer && w_sel_nz;
            if (w_xfer) begin
                r_last_grant <= w_gidx;
            end
            // Writes to x0 are consumed but leave the port's last values intact.
            if (w_xfer && w_sel_nz) begin
                r_wb_rd   <= w_sel_rd;
                r_wb_data <= w_sel_data;
            end
        end
    end

    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid) begin
            w_busy_set[issue_rd] = 1'b1;
        end
        if (w_xfer) begin
            w_busy_clr[w_sel_rd] = 1'b1;
        end
        // Set is applied after clear so a same-index collision stays busy.
        w_busy_nxt    = flush ? '0 : ((r_busy & ~w_busy_clr) | w_busy_set);
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rs1_busy = r_busy[chk_rs1] |
                      (r_wb_we && (r_wb_rd == chk_rs1) && (chk_rs1 != '0));
    assign rs2_busy = r_busy[chk_rs2] |
                      (r_wb_we && (r_wb_rd == chk_rs2) && (chk_rs2 != '0));

    assign wb_we   = r_wb_we;
    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*5-1:0]    req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic [4:0]           chk_rs1;
    logic [4:0]           chk_rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 flush;
    logic                 wb_we;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_data;

    int n_pass;
    int n_total;

    regfile_wb_arbiter #(
        .NREQ (NREQ),
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n       = 1'b0;
        req_valid   = 3'b111;
        req_rd      = {5'd3, 5'd2, 5'd1};
        req_data    = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        chk_rs1     = 5'd4;
        chk_rs2     = 5'd1;
        flush       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (wb_we !== 1'b0) $display("FAIL reset_we: got %b want 0", wb_we);
        else n_pass++;
        n_total++;
        if (wb_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", wb_rd);
        else n_pass++;
        n_total++;
        if (wb_data !== 32'd0) $display("FAIL reset_data: got %h want 0", wb_data);
        else n_pass++;
        n_total++;
        if (rs1_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rs1_busy);
        else n_pass++;
        issue_valid = 1'b0;
        rst_n       = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 3'b001) $display("FAIL reset_first_grant: got %b want 001", req_ready);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_ready;
        for (int k = 0; k < 6; k++) begin
            exp_ready = 3'b001 << (k % 3);
            @(negedge clk);
            n_total++;
            if (req_ready !== exp_ready)
                $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
            else n_pass++;
            @(posedge clk);
            #1;
            n_total++;
            if (wb_we !== 1'b1 || wb_rd !== 5'((k % 3) + 1) || wb_data !== 32'(32'hC0 + (k % 3)))
                $display("FAIL fair_wb[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                         k, wb_we, wb_rd, wb_data, (k % 3) + 1, 32'hC0 + (k % 3));
            else n_pass++;
        end
    endtask

    task automatic test_single_write();
        req_valid = 3'b010;
        req_rd    = {5'd0, 5'd5, 5'd0};
        req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
        @(negedge clk);
        n_total++;
        if (req_ready !== 3'b010) $display("FAIL single_ready: got %b want 010", req_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        n_total++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF)
            $display("FAIL single_wb: got we=%b rd=%0d data=%h want we=1 rd=5 data=deadbeef",
                     wb_we, wb_rd, wb_data);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF)
            $display("FAIL idle_hold: got we=%b rd=%0d data=%h want we=0 rd=5 data=deadbeef",
                     wb_we, wb_rd, wb_data);
        else n_pass++;
    endtask

    task automatic test_x0();
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd0};
        req_data  = {32'd0, 32'd0, 32'h0000_1234};
        chk_rs1   = 5'd0;
        @(negedge clk);
        n_total++;
        if (req_ready !== 3'b001) $display("FAIL x0_ready: got %b want 001", req_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        n_total++;
        if (wb_we !== 1'b0) $display("FAIL x0_we: got %b want 0", wb_we);
        else n_pass++;
        n_total++;
        if (rs1_busy !== 1'b0) $display("FAIL x0_rs1_busy: got %b want 0", rs1_busy);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        chk_rs2     = 5'd7;
        @(negedge clk);
        n_total++;
        if (rs2_busy !== 1'b0) $display("FAIL sb_pre_issue: got %b want 0", rs2_busy);
        else n_pass++;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        n_total++;
        if (rs2_busy !== 1'b1) $display("FAIL sb_issued: got %b want 1", rs2_busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (rs2_busy !== 1'b1) $display("FAIL sb_held: got %b want 1", rs2_busy);
        else n_pass++;
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd7};
        req_data  = {32'd0, 32'd0, 32'h0000_0077};
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        n_total++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd7 || rs2_busy !== 1'b1)
            $display("FAIL sb_wb_forward: got we=%b rd=%0d busy=%b want we=1 rd=7 busy=1",
                     wb_we, wb_rd, rs2_busy);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (rs2_busy !== 1'b0) $display("FAIL sb_cleared: got %b want 0", rs2_busy);
        else n_pass++;
        issue_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 3'b001;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        req_valid   = 3'b000;
        @(posedge clk);
        #1;
        n_total++;
        if (wb_we !== 1'b0 || rs2_busy !== 1'b1)
            $display("FAIL sb_set_wins: got we=%b busy=%b want we=0 busy=1", wb_we, rs2_busy);
        else n_pass++;
    endtask

    task automatic test_flush();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        @(posedge clk);
        #1;
        issue_rd = 5'd9;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        chk_rs1     = 5'd3;
        chk_rs2     = 5'd9;
        #1;
        n_total++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1)
            $display("FAIL flush_pre: got rs1=%b rs2=%b want 1 1", rs1_busy, rs2_busy);
        else n_pass++;
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        n_total++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL flush_clear: got rs1=%b rs2=%b want 0 0", rs1_busy, rs2_busy);
        else n_pass++;
        chk_rs2 = 5'd7;
        #1;
        n_total++;
        if (rs2_busy !== 1'b0) $display("FAIL flush_rd7: got %b want 0", rs2_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        req_valid = 3'b010;
        req_rd    = {5'd0, 5'd12, 5'd0};
        req_data  = {32'd0, 32'hCAFE_0012, 32'd0};
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0)
            $display("FAIL rstmid_async: got we=%b rd=%0d data=%h want 0 0 0", wb_we, wb_rd, wb_data);
        else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd0)
            $display("FAIL rstmid_no_wb: got we=%b rd=%0d want we=0 rd=0", wb_we, wb_rd);
        else n_pass++;
        req_valid = 3'b111;
        #1;
        n_total++;
        if (req_ready !== 3'b001) $display("FAIL rstmid_ptr: got %b want 001", req_ready);
        else n_pass++;
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        n_total++;
        if (wb_we !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", wb_we);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fairness();
        test_single_write();
        test_x0();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
